// File: rtl/fir_result_tx.sv
// FIR result transmitter: small FIFO feeding a framed MSB-first serial link.
// Drops and flags words that arrive while the FIFO is full.
module fir_result_tx #(
  parameter int OutWidth  = 16,
  parameter int FifoDepth = 4,
  parameter int ClkDiv    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OutWidth-1:0]          in,
  input  logic                         valid,
  input  logic                         ovf_clr,
  output logic                         sclk,
  output logic                         sdata,
  output logic                         frame,
  output logic                         overflow,
  output logic [$clog2(FifoDepth):0]   level
);

  localparam int AW = $clog2(FifoDepth);
  localparam int DW = $clog2(2 * ClkDiv);
  localparam int BW = $clog2(OutWidth);

  localparam logic [DW-1:0] DivLast = DW'(2 * ClkDiv - 1);
  localparam logic [DW-1:0] DivHi   = DW'(ClkDiv - 1);
  localparam logic [AW:0]   Full    = (AW + 1)'(FifoDepth);
  localparam logic [BW-1:0] BitTop  = BW'(OutWidth - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [OutWidth-1:0] mem [FifoDepth];
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [AW:0]         level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [OutWidth-1:0] sh_q, sh_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DW-1:0]       div_q, div_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                frame_q, frame_d;

  logic                pop;
  logic                push;
  logic                drop;
  logic [OutWidth-1:0] head;

  assign pop  = (state_q == LOAD);
  assign push = valid && ((level_q != Full) || pop);
  assign drop = valid && !push;
  assign head = mem[rptr_q];

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in;
  end

  // FIFO pointers, occupancy and sticky drop flag (a drop beats a clear)
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Serializer FSM; outputs are computed one cycle ahead and registered
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        frame_d = 1'b0;
        if (level_q != '0) state_d = LOAD;
      end
      LOAD: begin
        sh_d    = head;
        bit_d   = BitTop;
        div_d   = '0;
        frame_d = 1'b1;
        sdata_d = head[OutWidth-1];
        sclk_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = GAP;
            frame_d = 1'b0;
            sdata_d = 1'b0;
          end else begin
            bit_d   = bit_q - 1'b1;
            sh_d    = sh_q << 1;
            sdata_d = sh_q[OutWidth-2];
          end
        end else begin
          div_d = div_q + 1'b1;
          if (div_q == DivHi) sclk_d = 1'b1;
        end
      end
      GAP: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        frame_d = 1'b0;
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = (level_q != '0) ? LOAD : IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      frame_q <= frame_d;
    end
  end

  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign frame    = frame_q;
  assign overflow = ovf_q;
  assign level    = level_q;

endmodule
